uart_tx_arbiter: RTL

- Shares one UART transmitter (transmit / TX_Data / busy handshake) between NUM_REQ byte-producing requesters.
- Round-robin arbitration; one byte per grant.
- Sits between requester logic and the UART top's TX inputs.
- Captures the winning byte, drives transmit until the UART reports busy, acks the requester, then waits for the frame to finish before re-arbitrating.

---
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Optional same-owner packet locking is compiled in with `define UART_ARB_LOCK_EN.
//
// state | meaning
// IDLE  | waiting for a request while the UART is not busy
// ISSUE | transmit held high, waiting for busy (or timeout)
// DRAIN | byte accepted, waiting for the frame to finish (busy low)
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 8,
  parameter int ISSUE_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_lock,
`endif
  output logic [NUM_REQ-1:0]         ack,
  output logic                       timeout_err,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       active,
  output logic                       transmit,
  output logic [DATA_W-1:0]          TX_Data,
  input  logic                       busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (ISSUE_TIMEOUT > 1) ? $clog2(ISSUE_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   winner;
  logic               win_valid;
  logic               grant;
  logic               timeout_hit;
  logic               relock;
  logic [PTR_W-1:0]   drain_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // First set request searching upward from the round-robin pointer, with wrap.
  always_comb begin
    int idx;
    idx       = 0;
    winner    = '0;
    win_valid = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (req[idx]) begin
        winner    = PTR_W'(idx);
        win_valid = 1'b1;
      end
    end
  end

  assign grant       = (state == IDLE) && win_valid && !busy;
  assign timeout_hit = (state == ISSUE) && !busy && (cnt == CNT_W'(ISSUE_TIMEOUT-1));

`ifdef UART_ARB_LOCK_EN
  assign relock = req_lock[owner] & req[owner];
`else
  assign relock = 1'b0;
`endif

  // A locked owner keeps the pointer so it wins again from IDLE.
  assign drain_ptr = relock ? owner : ptr_inc(owner);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE: begin
        if (busy)             state_nxt = DRAIN;
        else if (timeout_hit) state_nxt = IDLE;
      end
      DRAIN:   if (!busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    transmit = (state == ISSUE);
    active   = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ack         <= '0;
      timeout_err <= 1'b0;
      owner       <= '0;
      TX_Data     <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
    end else begin
      ack         <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            TX_Data <= req_data[int'(winner)*DATA_W +: DATA_W];
            owner   <= winner;
            cnt     <= '0;
          end
        end
        ISSUE: begin
          if (busy) begin
            ack <= NUM_REQ'(1) << owner;
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            rr_ptr      <= ptr_inc(owner);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (!busy) rr_ptr <= drain_ptr;
        end
        default: ;
      endcase
    end
  end

endmodule
